// File: rtl/zx_pkg.sv
// Shared types and constants for the ZX Spectrum memory pager:
// paging modes, region codes, SRAM sequencer states and bank helpers.
package zx_pkg;

  typedef enum logic [1:0] {
    MODE_48K  = 2'd0,
    MODE_128K = 2'd1,
    MODE_EXT  = 2'd2
  } zx_mode_e;

  typedef enum logic [1:0] {
    REGION_ROM  = 2'b00,
    REGION_VRAM = 2'b01,
    REGION_SRAM = 2'b10
  } zx_region_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    HOLD   = 2'd3
  } zx_state_e;

  localparam logic [4:0]  BANK_SCREEN    = 5'd5;
  localparam logic [4:0]  BANK_SHADOW    = 5'd7;
  localparam logic [4:0]  BANK_MID       = 5'd2;
  // Only A[15] and A[1] take part in the 0x7FFD decode.
  localparam logic [15:0] PORT_7FFD_MASK = 16'h8002;

  function automatic logic is_vram_bank(input logic [4:0] bank);
    return (bank == BANK_SCREEN) || (bank == BANK_SHADOW);
  endfunction

  // Extended mode appends D[6] then D[7] above the classic D[2:0] bank field.
  function automatic logic [4:0] bank_from_data(input logic [7:0] d, input logic ext);
    return ext ? {d[7], d[6], d[2:0]} : {2'b00, d[2:0]};
  endfunction

endpackage

// File: rtl/zx_wait_gen.sv
// External SRAM access sequencer: inserts nWAIT states on an SRAM memory
// cycle and issues a single-clock write strobe.
module zx_wait_gen
  import zx_pkg::*;
#(
  parameter int WAIT_CYCLES = 0
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic n_mreq_i,
  input  logic n_iorq_i,
  input  logic n_rd_i,
  input  logic n_wr_i,
  input  logic n_rfsh_i,
  input  logic sram_sel_i,
  output logic n_wait_o,
  output logic sram_we_o
);

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);
  localparam logic       HAS_WAIT  = (WAIT_CYCLES > 0);

  zx_state_e  state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       n_wait_q, n_wait_d;
  logic       sram_we_q, sram_we_d;
  logic       mreq_prev_q;
  logic       start_s;

  // A colliding I/O cycle belongs to the port write, so it never starts an access.
  assign start_s = mreq_prev_q & ~n_mreq_i & n_rfsh_i & n_iorq_i & sram_sel_i;

  // Next-state, wait counter and write-strobe decode.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sram_we_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_s) begin
          cnt_d   = WAIT_LOAD;
          state_d = HAS_WAIT ? WAIT : ACCESS;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = ACCESS;
        end else begin
          state_d = WAIT;
        end
      end
      ACCESS: begin
        if (!n_wr_i && n_rfsh_i) begin
          sram_we_d = 1'b1;
          state_d   = HOLD;
        end else if (!n_rd_i) begin
          state_d = HOLD;
        end else begin
          state_d = ACCESS;
        end
      end
      HOLD: begin
        if (n_mreq_i) begin
          state_d = IDLE;
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    n_wait_d = (state_d != WAIT);
  end

  // Sequencer registers; nMREQ keeps being sampled in reset so release cannot fake an edge.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      n_wait_q    <= 1'b1;
      sram_we_q   <= 1'b0;
      mreq_prev_q <= n_mreq_i;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      n_wait_q    <= n_wait_d;
      sram_we_q   <= sram_we_d;
      mreq_prev_q <= n_mreq_i;
    end
  end

  assign n_wait_o  = n_wait_q;
  assign sram_we_o = sram_we_q;

endmodule

// File: rtl/zx_mem_pager.sv
// ZX Spectrum memory pager: 0x7FFD paging register, address map to
// Flash/VRAM/SRAM, and the SRAM wait-state sequencer.
module zx_mem_pager
  import zx_pkg::*;
#(
  parameter int MODE        = 1,
  parameter int BANK_BITS   = 3,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                  clk_cpu,
  input  logic                  reset,
  input  logic [15:0]           A,
  input  logic [7:0]            D,
  input  logic                  nMREQ,
  input  logic                  nIORQ,
  input  logic                  nRD,
  input  logic                  nWR,
  input  logic                  nM1,
  input  logic                  nRFSH,
  output logic                  nWAIT,
  output logic [14:0]           rom_addr,
  output logic [BANK_BITS+13:0] sram_addr,
  output logic                  sram_we,
  output logic [14:0]           vram_addr,
  output logic                  vram_we,
  output logic                  vram_shadow,
  output logic [1:0]            region
);

  localparam logic PAGING_EN = (MODE != int'(MODE_48K));
  localparam logic EXT_EN    = (MODE == int'(MODE_EXT));

  logic [BANK_BITS-1:0] bank_q, bank_d;
  logic                 screen_q, screen_d;
  logic                 rom_sel_q, rom_sel_d;
  logic                 lock_q, lock_d;
  logic                 io_prev_q;
  logic                 port_hit_s;
  logic                 port_load_s;
  logic [BANK_BITS-1:0] sel_bank_s;
  zx_region_e           region_s;
  logic                 sram_sel_s;

  assign port_hit_s  = ~nIORQ & ~nWR & nM1 & ((A & PORT_7FFD_MASK) == 16'h0000);
  assign port_load_s = port_hit_s & ~io_prev_q & ~lock_q & PAGING_EN;

  // Paging register next state: load only on the first clock of a port write.
  always_comb begin
    bank_d    = bank_q;
    screen_d  = screen_q;
    rom_sel_d = rom_sel_q;
    lock_d    = lock_q;
    if (port_load_s) begin
      bank_d    = BANK_BITS'(bank_from_data(D, EXT_EN));
      screen_d  = D[3];
      rom_sel_d = D[4];
      lock_d    = D[5];
    end else begin
      bank_d    = bank_q;
      screen_d  = screen_q;
      rom_sel_d = rom_sel_q;
      lock_d    = lock_q;
    end
  end

  // Paging register and port-decode edge history.
  always_ff @(posedge clk_cpu) begin
    if (reset) begin
      bank_q    <= '0;
      screen_q  <= 1'b0;
      rom_sel_q <= 1'b0;
      lock_q    <= 1'b0;
      io_prev_q <= 1'b0;
    end else begin
      bank_q    <= bank_d;
      screen_q  <= screen_d;
      rom_sel_q <= rom_sel_d;
      lock_q    <= lock_d;
      io_prev_q <= port_hit_s;
    end
  end

  // Address map: the top quarter follows the register, the middle quarters are fixed.
  always_comb begin
    sel_bank_s = '0;
    region_s   = REGION_ROM;
    case (A[15:14])
      2'b00:   sel_bank_s = '0;
      2'b01:   sel_bank_s = BANK_BITS'(BANK_SCREEN);
      2'b10:   sel_bank_s = BANK_BITS'(BANK_MID);
      2'b11:   sel_bank_s = PAGING_EN ? bank_q : '0;
      default: sel_bank_s = '0;
    endcase
    if (A[15:14] == 2'b00) begin
      region_s = REGION_ROM;
    end else if (is_vram_bank(5'(sel_bank_s))) begin
      region_s = REGION_VRAM;
    end else begin
      region_s = REGION_SRAM;
    end
  end

  assign sram_sel_s  = (region_s == REGION_SRAM);
  assign region      = region_s;
  assign rom_addr    = {rom_sel_q, A[13:0]};
  assign sram_addr   = {sel_bank_s, A[13:0]};
  assign vram_addr   = {sel_bank_s == BANK_BITS'(BANK_SHADOW), A[13:0]};
  assign vram_we     = ~nMREQ & ~nWR & nRFSH & (region_s == REGION_VRAM);
  assign vram_shadow = screen_q;

  zx_wait_gen #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_wait_gen (
    .clk_i     (clk_cpu),
    .reset_i   (reset),
    .n_mreq_i  (nMREQ),
    .n_iorq_i  (nIORQ),
    .n_rd_i    (nRD),
    .n_wr_i    (nWR),
    .n_rfsh_i  (nRFSH),
    .sram_sel_i(sram_sel_s),
    .n_wait_o  (nWAIT),
    .sram_we_o (sram_we)
  );

endmodule

// File: tb/tb_zx_mem_pager.sv
// Self-checking bench for zx_mem_pager: four parameter sets share one CPU
// bus and are compared against a behavioural paging/wait model.
module tb_zx_mem_pager;

  localparam int NI   = 4;
  localparam int NCYC = 8;
  localparam int P_MODE [NI] = '{1, 1, 2, 0};
  localparam int P_BB   [NI] = '{3, 3, 5, 3};
  localparam int P_WC   [NI] = '{0, 3, 2, 0};

  logic        clk_cpu = 1'b0;
  logic        reset;
  logic [15:0] A;
  logic [7:0]  D;
  logic        nMREQ, nIORQ, nRD, nWR, nM1, nRFSH;

  logic        nwait_w  [NI];
  logic [14:0] rom_w    [NI];
  logic        swe_w    [NI];
  logic [14:0] va_w     [NI];
  logic        vwe_w    [NI];
  logic        shadow_w [NI];
  logic [1:0]  region_w [NI];
  logic [18:0] sa_w     [NI];
  logic [16:0] sa0, sa1, sa3;
  logic [18:0] sa2;

  assign sa_w[0] = {2'b00, sa0};
  assign sa_w[1] = {2'b00, sa1};
  assign sa_w[2] = sa2;
  assign sa_w[3] = {2'b00, sa3};

  int m_bank [NI];
  int m_screen [NI];
  int m_rom [NI];
  int m_lock [NI];
  int total;
  int bad;

  always #5 clk_cpu = ~clk_cpu;

  zx_mem_pager #(.MODE(1), .BANK_BITS(3), .WAIT_CYCLES(0)) dut0 (
    .clk_cpu(clk_cpu), .reset(reset), .A(A), .D(D), .nMREQ(nMREQ), .nIORQ(nIORQ),
    .nRD(nRD), .nWR(nWR), .nM1(nM1), .nRFSH(nRFSH), .nWAIT(nwait_w[0]),
    .rom_addr(rom_w[0]), .sram_addr(sa0), .sram_we(swe_w[0]), .vram_addr(va_w[0]),
    .vram_we(vwe_w[0]), .vram_shadow(shadow_w[0]), .region(region_w[0]));

  zx_mem_pager #(.MODE(1), .BANK_BITS(3), .WAIT_CYCLES(3)) dut1 (
    .clk_cpu(clk_cpu), .reset(reset), .A(A), .D(D), .nMREQ(nMREQ), .nIORQ(nIORQ),
    .nRD(nRD), .nWR(nWR), .nM1(nM1), .nRFSH(nRFSH), .nWAIT(nwait_w[1]),
    .rom_addr(rom_w[1]), .sram_addr(sa1), .sram_we(swe_w[1]), .vram_addr(va_w[1]),
    .vram_we(vwe_w[1]), .vram_shadow(shadow_w[1]), .region(region_w[1]));

  zx_mem_pager #(.MODE(2), .BANK_BITS(5), .WAIT_CYCLES(2)) dut2 (
    .clk_cpu(clk_cpu), .reset(reset), .A(A), .D(D), .nMREQ(nMREQ), .nIORQ(nIORQ),
    .nRD(nRD), .nWR(nWR), .nM1(nM1), .nRFSH(nRFSH), .nWAIT(nwait_w[2]),
    .rom_addr(rom_w[2]), .sram_addr(sa2), .sram_we(swe_w[2]), .vram_addr(va_w[2]),
    .vram_we(vwe_w[2]), .vram_shadow(shadow_w[2]), .region(region_w[2]));

  zx_mem_pager #(.MODE(0), .BANK_BITS(3), .WAIT_CYCLES(0)) dut3 (
    .clk_cpu(clk_cpu), .reset(reset), .A(A), .D(D), .nMREQ(nMREQ), .nIORQ(nIORQ),
    .nRD(nRD), .nWR(nWR), .nM1(nM1), .nRFSH(nRFSH), .nWAIT(nwait_w[3]),
    .rom_addr(rom_w[3]), .sram_addr(sa3), .sram_we(swe_w[3]), .vram_addr(va_w[3]),
    .vram_we(vwe_w[3]), .vram_shadow(shadow_w[3]), .region(region_w[3]));

  // ---------------- reference model ----------------
  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      m_bank[i] = 0; m_screen[i] = 0; m_rom[i] = 0; m_lock[i] = 0;
    end
  endtask

  task automatic model_port(input int addr, input int data, input logic m1);
    if (((addr / 32768) % 2 == 0) && ((addr / 2) % 2 == 0) && m1) begin
      for (int i = 0; i < NI; i++) begin
        if (P_MODE[i] != 0 && m_lock[i] == 0) begin
          int b;
          b = data % 8;
          if (P_MODE[i] == 2 && P_BB[i] >= 4) b = b + ((data / 64) % 2) * 8;
          if (P_MODE[i] == 2 && P_BB[i] >= 5) b = b + ((data / 128) % 2) * 16;
          m_bank[i]   = b;
          m_screen[i] = (data / 8) % 2;
          m_rom[i]    = (data / 16) % 2;
          m_lock[i]   = (data / 32) % 2;
        end
      end
    end
  endtask

  function automatic int exp_bank(input int i, input int addr);
    int page;
    page = addr / 16384;
    if (page == 1) return 5;
    else if (page == 2) return 2;
    else if (page == 3) return (P_MODE[i] == 0) ? 0 : m_bank[i];
    else return 0;
  endfunction

  function automatic int exp_region(input int i, input int addr);
    int b;
    b = exp_bank(i, addr);
    if (addr < 16384) return 0;
    else if (b == 5 || b == 7) return 1;
    else return 2;
  endfunction

  // ---------------- bus drivers ----------------
  task automatic bus_idle();
    nMREQ = 1'b1; nIORQ = 1'b1; nRD = 1'b1; nWR = 1'b1; nM1 = 1'b1; nRFSH = 1'b1;
  endtask

  task automatic step();
    @(posedge clk_cpu);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus_idle();
    step();
    step();
    reset = 1'b0;
    model_reset();
  endtask

  task automatic io_write(input logic [15:0] addr, input logic [7:0] data, input logic m1);
    A = addr; D = data; nM1 = m1; nIORQ = 1'b0; nWR = 1'b0;
    step();
    step();
    bus_idle();
    step();
    model_port(int'(addr), int'(data), m1);
  endtask

  // kind: 0 read, 1 write, 2 refresh, 3 write colliding with nIORQ
  task automatic mem_cycle(input int kind, input logic [15:0] addr);
    int wcnt [NI];
    int wecnt [NI];
    int vcnt [NI];
    int exp_sa [NI];
    int reg_e [NI];
    int off, b, ew, ewe, ev;
    off = int'(addr) % 16384;
    A = addr; nMREQ = 1'b0;
    nRD   = (kind == 0) ? 1'b0 : 1'b1;
    nWR   = (kind == 1 || kind == 3) ? 1'b0 : 1'b1;
    nRFSH = (kind == 2) ? 1'b0 : 1'b1;
    nIORQ = (kind == 3) ? 1'b0 : 1'b1;
    #1;
    for (int i = 0; i < NI; i++) begin
      b = exp_bank(i, int'(addr));
      reg_e[i] = exp_region(i, int'(addr));
      exp_sa[i] = b * 16384 + off;
      wcnt[i] = 0; wecnt[i] = 0; vcnt[i] = 0;
      total++;
      if (region_w[i] !== 2'(reg_e[i])) begin
        bad++; $display("FAIL region inst%0d addr=%h got=%b want=%0d", i, addr, region_w[i], reg_e[i]);
      end
      total++;
      if (rom_w[i] !== 15'(m_rom[i] * 16384 + off)) begin
        bad++; $display("FAIL rom_addr inst%0d addr=%h got=%h want=%h", i, addr, rom_w[i], m_rom[i] * 16384 + off);
      end
      total++;
      if (shadow_w[i] !== 1'(m_screen[i])) begin
        bad++; $display("FAIL vram_shadow inst%0d got=%b want=%0d", i, shadow_w[i], m_screen[i]);
      end
      if (reg_e[i] == 2) begin
        total++;
        if (sa_w[i] !== 19'(exp_sa[i])) begin
          bad++; $display("FAIL sram_addr inst%0d addr=%h got=%h want=%h", i, addr, sa_w[i], exp_sa[i]);
        end
      end
      if (reg_e[i] == 1) begin
        total++;
        if (va_w[i] !== 15'(((b == 7) ? 16384 : 0) + off)) begin
          bad++; $display("FAIL vram_addr inst%0d addr=%h got=%h want=%h", i, addr, va_w[i], ((b == 7) ? 16384 : 0) + off);
        end
      end
    end
    for (int c = 0; c < NCYC + 3; c++) begin
      if (c == NCYC) bus_idle();
      step();
      for (int i = 0; i < NI; i++) begin
        if (!nwait_w[i]) wcnt[i]++;
        if (c < NCYC && vwe_w[i]) vcnt[i]++;
        if (swe_w[i]) begin
          wecnt[i]++;
          total++;
          if (sa_w[i] !== 19'(exp_sa[i])) begin
            bad++; $display("FAIL we_addr inst%0d got=%h want=%h", i, sa_w[i], exp_sa[i]);
          end
        end
      end
    end
    for (int i = 0; i < NI; i++) begin
      ew  = (reg_e[i] == 2 && (kind == 0 || kind == 1)) ? P_WC[i] : 0;
      ewe = (reg_e[i] == 2 && kind == 1) ? 1 : 0;
      ev  = (reg_e[i] == 1 && kind == 1) ? NCYC : 0;
      total++;
      if (wcnt[i] !== ew) begin
        bad++; $display("FAIL wait_clocks inst%0d kind=%0d addr=%h got=%0d want=%0d", i, kind, addr, wcnt[i], ew);
      end
      total++;
      if (wecnt[i] !== ewe) begin
        bad++; $display("FAIL sram_we_pulses inst%0d kind=%0d addr=%h got=%0d want=%0d", i, kind, addr, wecnt[i], ewe);
      end
      total++;
      if (vcnt[i] !== ev) begin
        bad++; $display("FAIL vram_we_clocks inst%0d kind=%0d addr=%h got=%0d want=%0d", i, kind, addr, vcnt[i], ev);
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    A = 16'hC000;
    #1;
    for (int i = 0; i < NI; i++) begin
      total++;
      if (nwait_w[i] !== 1'b1) begin bad++; $display("FAIL reset_nwait inst%0d got=%b want=1", i, nwait_w[i]); end
      total++;
      if (swe_w[i] !== 1'b0) begin bad++; $display("FAIL reset_sram_we inst%0d got=%b want=0", i, swe_w[i]); end
      total++;
      if (region_w[i] !== 2'b10) begin bad++; $display("FAIL reset_region inst%0d got=%b want=10", i, region_w[i]); end
      total++;
      if (sa_w[i] !== 19'd0) begin bad++; $display("FAIL reset_sram_addr inst%0d got=%h want=0", i, sa_w[i]); end
    end
    mem_cycle(0, 16'hC000);
  endtask

  task automatic test_map_128k();
    do_reset();
    io_write(16'h7FFD, 8'h17, 1'b1);
    mem_cycle(1, 16'hC123);
    mem_cycle(0, 16'h4000);
    mem_cycle(1, 16'h0100);
  endtask

  task automatic test_lock();
    do_reset();
    io_write(16'h7FFD, 8'h20, 1'b1);
    io_write(16'h7FFD, 8'h03, 1'b1);
    mem_cycle(0, 16'hC000);
    do_reset();
    io_write(16'h7FFD, 8'h03, 1'b1);
    mem_cycle(0, 16'hC000);
  endtask

  task automatic test_wait_refresh();
    do_reset();
    mem_cycle(1, 16'h8000);
    mem_cycle(2, 16'h8000);
    mem_cycle(0, 16'h8000);
  endtask

  task automatic test_ext_bank();
    do_reset();
    io_write(16'h7FFD, 8'hC1, 1'b1);
    mem_cycle(0, 16'hC000);
    mem_cycle(1, 16'hC0AB);
  endtask

  task automatic test_io_edge();
    do_reset();
    A = 16'h7FFD; D = 8'h03; nIORQ = 1'b0; nWR = 1'b0;
    step();
    D = 8'h06;
    step();
    step();
    bus_idle();
    step();
    model_port(32'h7FFD, 32'h03, 1'b1);
    mem_cycle(0, 16'hC000);
    io_write(16'h7FFD, 8'h07, 1'b0);
    io_write(16'h7FFF, 8'h07, 1'b1);
    io_write(16'hFFFD, 8'h07, 1'b1);
    mem_cycle(1, 16'hC004);
  endtask

  task automatic test_collision();
    do_reset();
    mem_cycle(3, 16'hC000);
    mem_cycle(3, 16'h9234);
  endtask

  task automatic test_reset_in_wait();
    do_reset();
    A = 16'h8000; nMREQ = 1'b0; nWR = 1'b0;
    step();
    step();
    for (int i = 0; i < NI; i++) begin
      total++;
      if (nwait_w[i] !== ((P_WC[i] >= 2) ? 1'b0 : 1'b1)) begin
        bad++; $display("FAIL pre_reset_nwait inst%0d got=%b", i, nwait_w[i]);
      end
    end
    reset = 1'b1;
    step();
    for (int i = 0; i < NI; i++) begin
      total++;
      if (nwait_w[i] !== 1'b1) begin bad++; $display("FAIL midreset_nwait inst%0d got=%b want=1", i, nwait_w[i]); end
      total++;
      if (swe_w[i] !== 1'b0) begin bad++; $display("FAIL midreset_sram_we inst%0d got=%b want=0", i, swe_w[i]); end
    end
    bus_idle();
    step();
    reset = 1'b0;
    model_reset();
    for (int c = 0; c < 4; c++) begin
      step();
      for (int i = 0; i < NI; i++) begin
        total++;
        if (nwait_w[i] !== 1'b1 || swe_w[i] !== 1'b0) begin
          bad++; $display("FAIL post_reset_idle inst%0d nwait=%b we=%b want 1/0", i, nwait_w[i], swe_w[i]);
        end
      end
    end
    mem_cycle(1, 16'h8000);
  endtask

  task automatic test_random();
    for (int n = 0; n < 30; n++) begin
      int op;
      logic [15:0] ad;
      logic [7:0] dt;
      op = int'($urandom_range(0, 3));
      ad = 16'($urandom);
      dt = 8'($urandom);
      if (n % 8 == 7) do_reset();
      case (op)
        0: begin
          if ($urandom_range(0, 1) == 1) ad = ad & 16'h7FFD;
          if (dt[5] && $urandom_range(0, 3) != 0) dt[5] = 1'b0;
          io_write(ad, dt, ($urandom_range(0, 5) != 0));
        end
        1: mem_cycle(0, ad);
        2: mem_cycle(1, ad);
        default: mem_cycle(2, ad);
      endcase
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    reset = 1'b1;
    A = 16'h0000;
    D = 8'h00;
    bus_idle();
    model_reset();
    test_reset();
    test_map_128k();
    test_lock();
    test_wait_refresh();
    test_ext_bank();
    test_io_edge();
    test_collision();
    test_reset_in_wait();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
